// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: memory-wait stalls, load-use bubbles,
// branch flushes and operand forwarding selects, plus saturating event counters.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic [4:0]  e_dst,
  input  logic        mwreg,
  input  logic [4:0]  m_dst,
  input  logic        e_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        ifid_flush,
  output logic        idexe_bubble,
  output logic        pipe_hold,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        busy,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t state;
  logic   mem_stall;
  logic   load_use;
  logic   flush;
  logic   lu_stall;

  always_comb begin
    mem_stall = ((state == RUN) && mem_req && !mem_ready) ||
                ((state == MEM_WAIT) && !mem_ready);
    load_use  = ewreg && em2reg && (e_dst != 5'd0) &&
                ((id_use_rs && (e_dst == id_rs)) || (id_use_rt && (e_dst == id_rt)));
    // A frozen EXE stage holds the branch, so it is only acted on once the wait ends.
    flush     = e_branch_taken && !mem_stall;
    lu_stall  = load_use && !mem_stall && !e_branch_taken;
  end

  always_comb begin
    pc_wen       = 1'b0;
    ifid_wen     = 1'b0;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    pipe_hold    = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    busy         = 1'b0;
    if (!rst) begin
      busy = (state == MEM_WAIT);
      if (mem_stall) begin
        pipe_hold = 1'b1;
      end else if (flush) begin
        ifid_flush   = 1'b1;
        idexe_bubble = 1'b1;
        pc_wen       = 1'b1;
        ifid_wen     = 1'b1;
      end else if (lu_stall) begin
        idexe_bubble = 1'b1;
      end else begin
        pc_wen   = 1'b1;
        ifid_wen = 1'b1;
      end
      // EXE result is younger than MEM result, so it wins.
      if (ewreg && !em2reg && (e_dst != 5'd0) && (e_dst == id_rs)) fwd_a = 2'b01;
      else if (mwreg && (m_dst != 5'd0) && (m_dst == id_rs))       fwd_a = 2'b10;
      if (ewreg && !em2reg && (e_dst != 5'd0) && (e_dst == id_rt)) fwd_b = 2'b01;
      else if (mwreg && (m_dst != 5'd0) && (m_dst == id_rt))       fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      case (state)
        RUN:      if (mem_req && !mem_ready) state <= MEM_WAIT;
        MEM_WAIT: if (mem_ready) state <= RUN;
        default:  state <= RUN;
      endcase
      if ((mem_stall || lu_stall) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: a rule-level model predicts every cycle's
// outputs into a queue that a negedge monitor drains, plus directed scenario checks.
module tb_pipe_hazard_ctrl;

  localparam int W = 42;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, e_dst, m_dst;
  logic        id_use_rs, id_use_rt, ewreg, em2reg, mwreg;
  logic        e_branch_taken, mem_req, mem_ready;
  logic        pc_wen, ifid_wen, ifid_flush, idexe_bubble, pipe_hold, busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // model state: outstanding memory access and the two event counts
  int m_wait = 0, m_stall = 0, m_flush = 0;
  int n_wait = 0, n_stall = 0, n_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ewreg(ewreg), .em2reg(em2reg),
    .e_dst(e_dst), .mwreg(mwreg), .m_dst(m_dst), .e_branch_taken(e_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_wen(pc_wen), .ifid_wen(ifid_wen),
    .ifid_flush(ifid_flush), .idexe_bubble(idexe_bubble), .pipe_hold(pipe_hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic int sat_inc(int x);
    return (x >= 65535) ? 65535 : x + 1;
  endfunction

  function automatic logic [1:0] fwd_sel(logic [4:0] src);
    if (ewreg && !em2reg && e_dst != 0 && e_dst == src) return 2'b01;
    if (mwreg && m_dst != 0 && m_dst == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ewreg = 0; em2reg = 0; e_dst = 0; mwreg = 0; m_dst = 0;
    e_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_wait = n_wait; m_stall = n_stall; m_flush = n_flush;
    #1;
  endtask

  // Predict this cycle's outputs from current inputs, then wait to the sample point.
  task automatic settle();
    logic pw, iw, fl, bb, ph, bz, mstall, lu;
    logic [1:0] fa, fb;
    pw = 0; iw = 0; fl = 0; bb = 0; ph = 0; bz = 0; fa = 0; fb = 0;
    if (rst) begin
      n_wait = 0; n_stall = 0; n_flush = 0;
    end else begin
      mstall = (mem_req && !mem_ready) || (m_wait != 0 && !mem_ready);
      lu = ewreg && em2reg && e_dst != 0 &&
           ((id_use_rs && e_dst == id_rs) || (id_use_rt && e_dst == id_rt));
      n_stall = m_stall; n_flush = m_flush;
      if (mstall) begin
        ph = 1; n_stall = sat_inc(m_stall);
      end else if (e_branch_taken) begin
        fl = 1; bb = 1; pw = 1; iw = 1; n_flush = sat_inc(m_flush);
      end else if (lu) begin
        bb = 1; n_stall = sat_inc(m_stall);
      end else begin
        pw = 1; iw = 1;
      end
      n_wait = mstall ? 1 : 0;
      bz = (m_wait != 0);
      fa = fwd_sel(id_rs);
      fb = fwd_sel(id_rt);
    end
    exp_q.push_back({pw, iw, fl, bb, ph, fa, fb, bz, 16'(m_stall), 16'(m_flush)});
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_wen, ifid_wen, ifid_flush, idexe_bubble, pipe_hold, fwd_a, fwd_b, busy,
           stall_cnt, flush_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got pc%b ifid%b fl%b bub%b hold%b fa%b fb%b busy%b sc%0d fc%0d expected pc%b ifid%b fl%b bub%b hold%b fa%b fb%b busy%b sc%0d fc%0d",
          $time, a[41], a[40], a[39], a[38], a[37], a[36:35], a[34:33], a[32], a[31:16], a[15:0],
          e[41], e[40], e[39], e[38], e[37], e[36:35], e[34:33], e[32], e[31:16], e[15:0]);
      end
    end
  end

  task automatic do_reset();
    tick(); rst = 1; clear_inputs(); settle();
    tick(); rst = 0; settle();
  endtask

  initial begin
    int cnt_busy, cnt_hold, cnt_fl, base;
    rst = 1;
    clear_inputs();
    do_reset();
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    chk("reset_pc_wen", pc_wen, 1);

    // load-use: one bubble, then the load forwards from MEM
    tick(); ewreg = 1; em2reg = 1; e_dst = 5; id_use_rs = 1; id_rs = 5; settle();
    chk("lu_pc_wen", pc_wen, 0);
    chk("lu_bubble", idexe_bubble, 1);
    tick(); clear_inputs(); mwreg = 1; m_dst = 5; id_use_rs = 1; id_rs = 5; settle();
    chk("lu_fwd_a_mem", fwd_a, 2);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_pc_wen_after", pc_wen, 1);

    // forwarding: EXE beats MEM; register 0 never forwards
    tick(); clear_inputs(); ewreg = 1; e_dst = 3; mwreg = 1; m_dst = 3; id_rs = 3; id_rt = 3; settle();
    chk("fwd_a_exe", fwd_a, 1);
    chk("fwd_b_exe", fwd_b, 1);
    tick(); clear_inputs(); ewreg = 1; e_dst = 0; id_rs = 0; settle();
    chk("fwd_a_r0", fwd_a, 0);

    // memory wait: 4 unready cycles then ready
    cnt_busy = 0; cnt_hold = 0; base = stall_cnt;
    for (int i = 0; i < 6; i++) begin
      tick(); clear_inputs(); mem_req = (i < 5); mem_ready = (i == 4); settle();
      cnt_busy += busy; cnt_hold += pipe_hold;
    end
    chk("wait_busy_cycles", cnt_busy, 4);
    chk("wait_hold_cycles", cnt_hold, 4);
    chk("wait_stall_delta", stall_cnt - base, 4);

    // branch held through a 2-cycle wait: flushed once when the wait ends
    cnt_fl = 0; base = flush_cnt;
    for (int i = 0; i < 3; i++) begin
      tick(); clear_inputs(); e_branch_taken = 1; mem_req = 1; mem_ready = (i == 2); settle();
      cnt_fl += ifid_flush;
    end
    tick(); clear_inputs(); settle();
    chk("bw_flush_cycles", cnt_fl, 1);
    chk("bw_flush_delta", flush_cnt - base, 1);
    chk("bw_busy_clear", busy, 0);

    // branch plus load-use: flush wins, no stall counted
    base = stall_cnt;
    tick(); clear_inputs(); e_branch_taken = 1; ewreg = 1; em2reg = 1; e_dst = 7;
    id_use_rt = 1; id_rt = 7; settle();
    chk("bl_pc_wen", pc_wen, 1);
    chk("bl_bubble", idexe_bubble, 1);
    chk("bl_flush", ifid_flush, 1);
    tick(); clear_inputs(); settle();
    chk("bl_stall_same", stall_cnt, base);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 99) == 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      e_dst = 5'($urandom_range(0, 3)); m_dst = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      ewreg = 1'($urandom); em2reg = 1'($urandom); mwreg = 1'($urandom);
      e_branch_taken = ($urandom_range(0, 4) == 0);
      mem_req = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      settle();
    end

    // saturation: drive stall_cnt to the ceiling and beyond
    do_reset();
    clear_inputs();
    for (int i = 0; i < 65540; i++) begin
      tick(); mem_req = 1; mem_ready = 0; settle();
    end
    chk("sat_stall_cnt", stall_cnt, 65535);
    chk("sat_busy", busy, 1);

    // reset in the middle of the wait
    tick(); rst = 1; settle();
    chk("rst_pc_wen", pc_wen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hold", pipe_hold, 0);
    tick(); rst = 0; clear_inputs(); settle();
    chk("after_rst_stall_cnt", stall_cnt, 0);
    chk("after_rst_flush_cnt", flush_cnt, 0);
    chk("after_rst_pc_wen", pc_wen, 1);
    chk("after_rst_busy", busy, 0);

    tick();
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named as the codebase does: clk and rst.
REQ-002 Port list SHALL be exactly as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_rs  in  5  ID-stage rs field
- id_rt  in  5  ID-stage rt field
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ewreg  in  1  EXE instruction writes a register
- em2reg  in  1  EXE instruction is a load
- e_dst  in  5  EXE destination register (after regrt mux)
- mwreg  in  1  MEM instruction writes a register
- m_dst  in  5  MEM destination register
- e_branch_taken  in  1  branch resolved taken in EXE
- mem_req  in  1  MEM stage accesses data memory
- mem_ready  in  1  data memory completes this cycle
- pc_wen  out  1  PC write enable
- ifid_wen  out  1  IF/ID register write enable
- ifid_flush  out  1  IF/ID register loads NOP
- idexe_bubble  out  1  ID/EXE register loads all-zero controls (bubble)
- pipe_hold  out  1  freezes ID/EXE, EXE/MEM and MEM/WB registers
- fwd_a  out  2  source select for data_a: 00 regfile, 01 EXE ALU result, 10 MEM result
- fwd_b  out  2  same as fwd_a, for data_b
- busy  out  1  1 while in state MEM_WAIT
- stall_cnt  out  16  saturating count of stall cycles
- flush_cnt  out  16  saturating count of branch flushes

Function
REQ-003 The FSM SHALL have two states, RUN (reset state) and MEM_WAIT; the state SHALL be the only registered control, and all strobes SHALL be combinational from the state and the inputs.
REQ-004 In RUN, mem_req=1 with mem_ready=0 SHALL move the FSM to MEM_WAIT at the next edge; in MEM_WAIT, mem_ready=1 SHALL return the FSM to RUN at the next edge.
REQ-005 mem_stall = (RUN & mem_req & !mem_ready) | (MEM_WAIT & !mem_ready); when mem_stall=1: pc_wen=0, ifid_wen=0, pipe_hold=1, ifid_flush=0, idexe_bubble=0.
REQ-006 In MEM_WAIT, the cycle with mem_ready=1 SHALL be a normal (non-stalled) cycle; all other rules then apply as in RUN.
REQ-007 The load-use condition SHALL be: ewreg & em2reg & (e_dst!=0) & ((id_use_rs & e_dst==id_rs) | (id_use_rt & e_dst==id_rt)).
REQ-008 On a load-use condition without mem_stall: pc_wen=0, ifid_wen=0, idexe_bubble=1, pipe_hold=0; the stall SHALL last exactly 1 cycle per load.
REQ-009 On e_branch_taken=1 without mem_stall: ifid_flush=1, idexe_bubble=1, pc_wen=1, ifid_wen=1; the block SHALL suppress load-use stalling in that cycle.
REQ-010 Priority SHALL be rst > mem_stall > branch flush > load-use > normal; in a normal cycle pc_wen=1, ifid_wen=1, and all other strobes are 0.
REQ-011 fwd_a SHALL be 01 if ewreg & !em2reg & e_dst!=0 & e_dst==id_rs; else 10 if mwreg & m_dst!=0 & m_dst==id_rs; else 00; EXE match SHALL win over MEM match.
REQ-012 fwd_b SHALL follow the same rule as fwd_a using id_rt; fwd_a and fwd_b SHALL be valid regardless of stall state.
REQ-013 stall_cnt SHALL increment by 1 on every mem_stall cycle and every load-use bubble cycle, saturating at 16'hFFFF.
REQ-014 flush_cnt SHALL increment by 1 on every flush cycle (REQ-009), saturating at 16'hFFFF.
REQ-015 A taken branch that is present during mem_stall SHALL NOT be counted and SHALL be acted upon in the first non-stalled cycle, since EXE is frozen.

Reset
REQ-016 With rst=1 at a rising edge: state=RUN, stall_cnt=0, flush_cnt=0.
REQ-017 While rst=1: pc_wen=0, ifid_wen=0, ifid_flush=0, idexe_bubble=0, pipe_hold=0, busy=0, fwd_a=00, fwd_b=00.
REQ-018 Reset asserted during MEM_WAIT SHALL abandon the wait and return the FSM to RUN with no residual stall.

Verification
REQ-019 Load-use: EXE lw with e_dst=5, ID use_rs=1 with id_rs=5 -> exactly 1 cycle with pc_wen=0 and idexe_bubble=1; stall_cnt=1; the next cycle has fwd_a=10.
REQ-020 Forwarding: EXE add with e_dst=3 and MEM dst=3, id_rs=3 and id_rt=3 -> fwd_a=01, fwd_b=01; e_dst=0 with id_rs=0 -> fwd_a=00.
REQ-021 Memory wait: mem_req=1 with mem_ready=0 for 4 cycles, then 1 -> busy=1 for 4 cycles, pipe_hold=1 for 4 cycles, stall_cnt=4, state back to RUN.
REQ-022 Branch during wait: e_branch_taken=1 throughout a 2-cycle memory wait -> no flush during the wait, then one ifid_flush=1 cycle; flush_cnt=1.
REQ-023 Branch with load-use in the same cycle -> flush only (pc_wen=1, idexe_bubble=1); stall_cnt unchanged.
REQ-024 Saturation/reset: preload stall_cnt=16'hFFFF, then another stall -> stall_cnt remains 16'hFFFF; assert rst during MEM_WAIT -> state RUN, both counters 0, pc_wen=1 on the first cycle after reset.
